// File: rtl/image_enhancement_pkg.sv
// Shared constants and state encoding for the contrast-stretch engine.
package image_enhancement_pkg;

    localparam int WIDTH      = 8;
    localparam int NUM_PIXELS = 16384;
    localparam int ADDR_W     = 14;
    localparam int FRAC       = 16;
    localparam int QW         = 25;

    localparam logic [7:0] PIX_MAX = 8'd255;

    typedef enum logic [1:0] {
        LOAD,
        DIVIDE,
        OUTPUT
    } state_t;

endpackage

// File: rtl/image_enhancement_if.sv
// Pixel stream bundle between source, stretch engine and writer.
interface image_enhancement_if;
    import image_enhancement_pkg::*;

    logic             in_en;
    logic [WIDTH-1:0] input_img;
    logic [WIDTH-1:0] enhanced_img;
    logic             en_out;

    modport master (
        output in_en,
        output input_img,
        input  enhanced_img,
        input  en_out
    );

    modport slave (
        input  in_en,
        input  input_img,
        output enhanced_img,
        output en_out
    );

endinterface

// File: rtl/enh_divider.sv
// Serial restoring divider: scale = floor(255 << FRAC / divisor) + 1.
module enh_divider import image_enhancement_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] scale
);

    localparam logic [QW-1:0] DIVIDEND = QW'(PIX_MAX) << FRAC;

    logic [QW-1:0] dvd;
    logic [QW-1:0] quo;
    logic [7:0]    rem;
    logic [7:0]    dsr;
    logic [4:0]    cnt;
    logic [8:0]    trial;
    logic          ge;

    assign trial = {rem, dvd[QW-1]};
    assign ge    = trial >= {1'b0, dsr};
    assign scale = quo + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dsr  <= '0;
            dvd  <= '0;
            quo  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy <= 1'b1;
                dsr  <= divisor;
                dvd  <= DIVIDEND;
                rem  <= '0;
                quo  <= '0;
                cnt  <= '0;
            end else if (busy) begin
                // remainder stays below divisor, so 8 bits suffice
                rem <= 8'(ge ? trial - {1'b0, dsr} : trial);
                dvd <= dvd << 1;
                quo <= {quo[QW-2:0], ge};
                cnt <= cnt + 1'b1;
                if (cnt == 5'(QW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_enhancement.sv
// Frame min/max contrast stretch: buffer a frame, find 255/range once,
// then replay the buffer through the scale factor.
module image_enhancement #(
    parameter int NUM_PIXELS = image_enhancement_pkg::NUM_PIXELS,
    parameter int ADDR_W     = image_enhancement_pkg::ADDR_W
) (
    input logic                clk,
    input logic                rst,
    image_enhancement_if.slave bus
);

    import image_enhancement_pkg::state_t;
    import image_enhancement_pkg::LOAD;
    import image_enhancement_pkg::DIVIDE;
    import image_enhancement_pkg::OUTPUT;
    import image_enhancement_pkg::FRAC;
    import image_enhancement_pkg::QW;
    import image_enhancement_pkg::PIX_MAX;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        mn;
    logic [7:0]        mx;
    logic [7:0]        off;
    logic [7:0]        rd_data;
    logic [7:0]        mem [NUM_PIXELS];
    logic              pass;
    logic              launched;
    logic              rd_vld;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [QW-1:0]     scale;
    logic [7:0]        range;
    logic [7:0]        diff;
    logic [7:0]        pix;
    logic [32:0]       prod;
    logic [16:0]       shf;
    logic              accept;
    logic              last;
    logic              go;

    assign accept = (state == LOAD) && bus.in_en;
    assign last   = (cnt == ADDR_W'(NUM_PIXELS - 1));
    assign range  = mx - mn;
    assign go     = !launched && (range == 8'd0 || !div_busy);

    enh_divider u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .divisor (range),
        .busy    (div_busy),
        .done    (div_done),
        .scale   (scale)
    );

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        unique case (state)
            LOAD:   if (accept && last) state_nxt = DIVIDE;
            DIVIDE: begin
                if (go) begin
                    if (range == 8'd0) state_nxt = OUTPUT;
                    else div_start = 1'b1;
                end else if (launched && div_done) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: if (last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            cnt      <= '0;
            mn       <= PIX_MAX;
            mx       <= '0;
            off      <= '0;
            pass     <= 1'b0;
            launched <= 1'b0;
            rd_vld   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= (state == OUTPUT);
            unique case (state)
                LOAD: if (bus.in_en) begin
                    cnt <= cnt + 1'b1;
                    if (bus.input_img < mn) mn <= bus.input_img;
                    if (bus.input_img > mx) mx <= bus.input_img;
                end
                DIVIDE: if (go) begin
                    launched <= 1'b1;
                    off      <= mn;
                    pass     <= (range == 8'd0);
                end
                OUTPUT: begin
                    launched <= 1'b0;
                    cnt      <= cnt + 1'b1;
                    // offset is held in off, so min/max can rearm now
                    if (last) begin
                        mn <= PIX_MAX;
                        mx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[cnt] <= bus.input_img;
        rd_data <= mem[cnt];
    end

    assign diff = rd_data - off;
    assign prod = 33'(diff) * 33'(scale);
    assign shf  = 17'(prod >> FRAC);
    assign pix  = pass ? rd_data
                : (|shf[16:8] ? PIX_MAX : shf[7:0]);

    assign bus.en_out       = rd_vld;
    assign bus.enhanced_img = rd_vld ? pix : '0;

endmodule

// File: tb/tb_image_enhancement.sv
// Randomised frame-level bench for the contrast-stretch engine
// (256-pixel build), compared against an arithmetic reference.
module tb_image_enhancement;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    image_enhancement_if bus ();

    image_enhancement #(
        .NUM_PIXELS (N),
        .ADDR_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void model(input int pix[$], output int exp[$]);
        int lo = 255;
        int hi = 0;
        longint s;
        longint v;
        exp.delete();
        foreach (pix[i]) begin
            if (pix[i] < lo) lo = pix[i];
            if (pix[i] > hi) hi = pix[i];
        end
        foreach (pix[i]) begin
            if (hi == lo) begin
                exp.push_back(pix[i]);
            end else begin
                s = (longint'(255) * 65536) / (hi - lo) + 1;
                v = (longint'(pix[i] - lo) * s) / 65536;
                exp.push_back(v > 255 ? 255 : int'(v));
            end
        end
    endfunction

    function automatic int mism(input int a[$], input int b[$]);
        int bad = 0;
        if (a.size() != b.size()) return 1;
        foreach (a[i]) if (a[i] != b[i]) bad++;
        return bad;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int pix[$], input bit gaps,
                             output int got[$], output int lat,
                             output int hi, output bit zero_ok);
        got.delete();
        lat = 0;
        hi = 0;
        zero_ok = 1'b1;
        foreach (pix[i]) begin
            if (gaps && i > 0) begin
                bus.in_en = 1'b0;
                bus.input_img = 8'($urandom);
                step();
            end
            bus.in_en = 1'b1;
            bus.input_img = 8'(pix[i]);
            step();
        end
        // junk offered while the engine is busy must be dropped
        while (bus.en_out !== 1'b1 && lat < 70) begin
            if (bus.enhanced_img !== 8'd0) zero_ok = 1'b0;
            bus.in_en = 1'($urandom);
            bus.input_img = 8'($urandom);
            step();
            lat++;
        end
        bus.in_en = 1'b0;
        while (bus.en_out === 1'b1 && hi < N + 8) begin
            got.push_back(int'(bus.enhanced_img));
            hi++;
            step();
        end
        if (bus.enhanced_img !== 8'd0) zero_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_en = 1'b1;
        bus.input_img = 8'd42;
        repeat (3) step();
        checks++;
        if (bus.en_out !== 1'b0) $display("FAIL reset_en_out got %b want 0", bus.en_out);
        else passed++;
        checks++;
        if (bus.enhanced_img !== 8'd0) $display("FAIL reset_img got %0d want 0", bus.enhanced_img);
        else passed++;
        bus.in_en = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ramp();
        int pix[$], got[$];
        int lat, hi;
        bit z;
        for (int i = 0; i < N; i++) pix.push_back(i % 256);
        run_frame(pix, 1'b0, got, lat, hi, z);
        checks++;
        if (hi !== N) $display("FAIL ramp_len got %0d want %0d", hi, N);
        else passed++;
        checks++;
        if (mism(got, pix) !== 0) $display("FAIL ramp_identity got %0d bad want 0", mism(got, pix));
        else passed++;
        checks++;
        if (lat > 64) $display("FAIL ramp_latency got %0d want <=64", lat);
        else passed++;
        checks++;
        if (z !== 1'b1) $display("FAIL ramp_idle_zero got %b want 1", z);
        else passed++;
    endtask

    task automatic test_cycle();
        int pix[$], got[$], pat[4];
        int lat, hi, bad;
        bit z;
        pat = '{0, 85, 170, 255};
        for (int i = 0; i < N; i++) pix.push_back(100 + i % 4);
        run_frame(pix, 1'b0, got, lat, hi, z);
        bad = 0;
        foreach (got[i]) if (got[i] != pat[i % 4]) bad++;
        checks++;
        if (hi !== N) $display("FAIL cycle_len got %0d want %0d", hi, N);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL cycle_values got %0d bad want 0", bad);
        else passed++;
    endtask

    task automatic test_constant();
        int pix[$], got[$];
        int lat, hi, bad;
        bit z;
        for (int i = 0; i < N; i++) pix.push_back(77);
        run_frame(pix, 1'b0, got, lat, hi, z);
        bad = 0;
        foreach (got[i]) if (got[i] != 77) bad++;
        checks++;
        if (hi !== N) $display("FAIL const_len got %0d want %0d", hi, N);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL const_values got %0d bad want 0", bad);
        else passed++;
    endtask

    task automatic test_gaps();
        int pix[$], got[$], exp[$];
        int lat, hi;
        bit z;
        for (int i = 0; i < N; i++) pix.push_back(int'($urandom_range(20, 220)));
        model(pix, exp);
        run_frame(pix, 1'b1, got, lat, hi, z);
        checks++;
        if (mism(got, exp) !== 0) $display("FAIL gaps_values got %0d bad want 0", mism(got, exp));
        else passed++;
        checks++;
        if (lat > 64) $display("FAIL gaps_latency got %0d want <=64", lat);
        else passed++;
        checks++;
        if (hi !== N) $display("FAIL gaps_len got %0d want %0d", hi, N);
        else passed++;
    endtask

    task automatic test_random();
        int pix[$], got[$], exp[$];
        int lat, hi, lo, span;
        bit z;
        for (int f = 0; f < 4; f++) begin
            pix.delete();
            lo = int'($urandom_range(0, 200));
            span = int'($urandom_range(1, 55));
            for (int i = 0; i < N; i++) pix.push_back(lo + int'($urandom_range(0, span)));
            pix[3] = lo;
            pix[9] = lo + span;
            model(pix, exp);
            run_frame(pix, 1'($urandom), got, lat, hi, z);
            checks++;
            if (mism(got, exp) !== 0) $display("FAIL rand%0d_values got %0d bad want 0", f, mism(got, exp));
            else passed++;
            checks++;
            if (got.size() > 9 && (got[3] !== 0 || got[9] !== 255))
                $display("FAIL rand%0d_ends got %0d,%0d want 0,255", f, got[3], got[9]);
            else if (got.size() <= 9) $display("FAIL rand%0d_ends got short frame want %0d", f, N);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_load();
        int pix[$], got[$], exp[$];
        int lat, hi;
        bit z;
        for (int i = 0; i < 100; i++) begin
            bus.in_en = 1'b1;
            bus.input_img = (i % 2 == 0) ? 8'd0 : 8'd255;
            step();
        end
        bus.in_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) pix.push_back(10 + i % 11);
        model(pix, exp);
        run_frame(pix, 1'b0, got, lat, hi, z);
        checks++;
        if (mism(got, exp) !== 0) $display("FAIL rst_load_values got %0d bad want 0", mism(got, exp));
        else passed++;
    endtask

    task automatic test_reset_mid_output();
        int pix[$], got[$], exp[$];
        int lat, hi, w;
        bit z;
        for (int i = 0; i < N; i++) begin
            bus.in_en = 1'b1;
            bus.input_img = 8'($urandom);
            step();
        end
        bus.in_en = 1'b0;
        w = 0;
        while (bus.en_out !== 1'b1 && w < 70) begin
            step();
            w++;
        end
        checks++;
        if (bus.en_out !== 1'b1) $display("FAIL rst_out_start got %b want 1", bus.en_out);
        else passed++;
        repeat (4) step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.en_out !== 1'b0 || bus.enhanced_img !== 8'd0)
            $display("FAIL rst_out_abort got %b/%0d want 0/0", bus.en_out, bus.enhanced_img);
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < N; i++) pix.push_back(int'($urandom_range(120, 130)));
        model(pix, exp);
        run_frame(pix, 1'b0, got, lat, hi, z);
        checks++;
        if (mism(got, exp) !== 0) $display("FAIL rst_out_next got %0d bad want 0", mism(got, exp));
        else passed++;
    endtask

    task automatic test_back_to_back();
        int pa[$], pb[$], got[$], exp[$];
        int lat, hi;
        bit z;
        for (int i = 0; i < N; i++) pa.push_back(50 + i % 11);
        for (int i = 0; i < N; i++) pb.push_back(i % 256);
        model(pa, exp);
        run_frame(pa, 1'b0, got, lat, hi, z);
        checks++;
        if (mism(got, exp) !== 0) $display("FAIL b2b_first got %0d bad want 0", mism(got, exp));
        else passed++;
        run_frame(pb, 1'b0, got, lat, hi, z);
        checks++;
        if (mism(got, pb) !== 0) $display("FAIL b2b_second got %0d bad want 0", mism(got, pb));
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_en = 1'b0;
        bus.input_img = 8'd0;
        test_reset();
        test_ramp();
        test_cycle();
        test_constant();
        test_gaps();
        test_random();
        test_reset_mid_load();
        test_reset_mid_output();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
